// File: rtl/pos_ctl_pkg.sv
// Shared types and helpers for the N-channel position controller.
//   state_t   : per-channel hold/repeat FSM states
//   dir_t     : debounced button direction
//   cnt_width : width of the per-channel frame counter
package pos_ctl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StRepeat = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DirNone = 2'd0,
        DirUp   = 2'd1,
        DirDown = 2'd2
    } dir_t;

    // Counter must be able to hold the larger of the two repeat intervals.
    function automatic int unsigned cnt_width(input int unsigned delay_frames,
                                              input int unsigned rate_frames);
        int unsigned max_frames;
        max_frames = (delay_frames > rate_frames) ? delay_frames : rate_frames;
        return (max_frames < 2) ? 1 : $clog2(max_frames + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-bit button conditioner: 2-FF synchroniser followed by a frame-count debouncer.
//   px_clk  : pixel clock
//   rst_n   : synchronous active-low reset
//   tick    : one-cycle frame enable
//   btn_raw : asynchronous raw button level
//   btn_deb : debounced level, changes only on tick
module btn_debounce #(
    parameter int unsigned DEB_FRAMES = 2
) (
    input  logic px_clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_deb
);

    localparam int unsigned DEB_W = (DEB_FRAMES < 2) ? 1 : $clog2(DEB_FRAMES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_FRAMES - 1);

    logic [1:0]       sync_q;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;

    always_ff @(posedge px_clk) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (tick) begin
            if (sync_q[1] != deb_q) begin
                // Flip on the DEB_FRAMES-th consecutive differing frame.
                if (cnt_q == DEB_LAST) begin
                    deb_d = sync_q[1];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    assign btn_deb = deb_q;

endmodule

// File: rtl/pos_ctl_n.sv
// N-channel up/down position controller, updated once per video frame.
//   px_clk   : pixel clock (only clock)
//   rst_n    : synchronous active-low reset
//   endframe : end-of-frame level; its rising edge produces one frame tick
//   btn_up   : raw up buttons, one per channel
//   btn_down : raw down buttons, one per channel
//   pos      : packed positions, channel i at [i*POS_W +: POS_W]
//   moved    : one-cycle pulse when a channel's position changes
module pos_ctl_n
    import pos_ctl_pkg::*;
#(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned POS_W        = 8,
    parameter int unsigned POS_MIN      = 0,
    parameter int unsigned POS_MAX      = 255,
    parameter int unsigned POS_INIT     = 128,
    parameter int unsigned STEP         = 1,
    parameter int unsigned WRAP         = 0,
    parameter int unsigned DEB_FRAMES   = 2,
    parameter int unsigned REPEAT_DELAY = 16,
    parameter int unsigned REPEAT_RATE  = 4
) (
    input  logic                      px_clk,
    input  logic                      rst_n,
    input  logic                      endframe,
    input  logic [CHANNELS-1:0]       btn_up,
    input  logic [CHANNELS-1:0]       btn_down,
    output logic [CHANNELS*POS_W-1:0] pos,
    output logic [CHANNELS-1:0]       moved
);

    localparam int unsigned CNT_W = cnt_width(REPEAT_DELAY, REPEAT_RATE);
    localparam int unsigned EXT_W = POS_W + 1;

    typedef logic [EXT_W-1:0] ext_t;

    localparam ext_t E_MIN   = ext_t'(POS_MIN);
    localparam ext_t E_MAX   = ext_t'(POS_MAX);
    localparam ext_t E_STEP  = ext_t'(STEP);
    localparam ext_t E_RANGE = ext_t'(POS_MAX - POS_MIN + 1);

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    // Frame tick pipeline: endframe sample -> tick to debouncers -> tick to FSMs.
    logic ef_q, ef_prev_q, tick_q, fsm_tick_q;

    always_ff @(posedge px_clk) begin
        if (!rst_n) begin
            ef_q       <= 1'b0;
            ef_prev_q  <= 1'b0;
            tick_q     <= 1'b0;
            fsm_tick_q <= 1'b0;
        end else begin
            ef_q       <= endframe;
            ef_prev_q  <= ef_q;
            tick_q     <= ef_q & ~ef_prev_q;
            fsm_tick_q <= tick_q;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic             up_deb, dn_deb;
        dir_t             dir;
        state_t           state_q, state_d;
        dir_t             run_dir_q, run_dir_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [POS_W-1:0] pos_q, pos_d, step_val;
        logic             moved_q, moved_d, step;
        ext_t             pos_ext, up_sum;

        btn_debounce #(
            .DEB_FRAMES(DEB_FRAMES)
        ) u_deb_up (
            .px_clk (px_clk),
            .rst_n  (rst_n),
            .tick   (tick_q),
            .btn_raw(btn_up[ch]),
            .btn_deb(up_deb)
        );

        btn_debounce #(
            .DEB_FRAMES(DEB_FRAMES)
        ) u_deb_dn (
            .px_clk (px_clk),
            .rst_n  (rst_n),
            .tick   (tick_q),
            .btn_raw(btn_down[ch]),
            .btn_deb(dn_deb)
        );

        always_comb begin
            unique case ({up_deb, dn_deb})
                2'b10:   dir = DirUp;
                2'b01:   dir = DirDown;
                default: dir = DirNone;
            endcase
        end

        // Candidate next position for a step in the current direction.
        always_comb begin
            pos_ext  = ext_t'(pos_q);
            up_sum   = pos_ext + E_STEP;
            step_val = pos_q;
            if (dir == DirUp) begin
                if (up_sum > E_MAX) begin
                    step_val = (WRAP != 0) ? POS_W'(up_sum - E_RANGE) : POS_W'(E_MAX);
                end else begin
                    step_val = POS_W'(up_sum);
                end
            end else if (dir == DirDown) begin
                if (pos_ext < E_MIN + E_STEP) begin
                    step_val = (WRAP != 0) ? POS_W'(pos_ext + E_RANGE - E_STEP)
                                           : POS_W'(E_MIN);
                end else begin
                    step_val = POS_W'(pos_ext - E_STEP);
                end
            end
        end

        always_comb begin
            state_d   = state_q;
            run_dir_d = run_dir_q;
            cnt_d     = cnt_q;
            step      = 1'b0;
            if (fsm_tick_q) begin
                unique case (state_q)
                    StIdle: begin
                        if (dir != DirNone) begin
                            step      = 1'b1;
                            run_dir_d = dir;
                            cnt_d     = '0;
                            state_d   = StDelay;
                        end
                    end
                    StDelay: begin
                        // Release or reversal returns to idle without stepping.
                        if (dir == DirNone || dir != run_dir_q) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else if (cnt_q == DELAY_LAST) begin
                            step    = 1'b1;
                            cnt_d   = '0;
                            state_d = StRepeat;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    StRepeat: begin
                        if (dir == DirNone || dir != run_dir_q) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else if (cnt_q == RATE_LAST) begin
                            step  = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        assign pos_d   = step ? step_val : pos_q;
        assign moved_d = step && (step_val != pos_q);

        always_ff @(posedge px_clk) begin
            if (!rst_n) begin
                state_q   <= StIdle;
                run_dir_q <= DirNone;
                cnt_q     <= '0;
                pos_q     <= POS_W'(POS_INIT);
                moved_q   <= 1'b0;
            end else begin
                state_q   <= state_d;
                run_dir_q <= run_dir_d;
                cnt_q     <= cnt_d;
                pos_q     <= pos_d;
                moved_q   <= moved_d;
            end
        end

        assign pos[ch*POS_W +: POS_W] = pos_q;
        assign moved[ch]              = moved_q;
    end

endmodule
